// File: rtl/serial_rx_pkg.sv
// Shared types and default parameters for the serial frame receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_rx_pkg;

  // Receiver phases: hunting for sync, collecting payload, checking parity.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  localparam int             SYNC_W_DEF    = 4;
  localparam logic [3:0]     SYNC_PAT_DEF  = 4'b1011;
  localparam int             DATA_W_DEF    = 8;
  localparam int             ERR_CNT_W_DEF = 8;

endpackage

// File: rtl/sync_matcher.sv
// Sync-pattern detector: shift register of recent bits plus a fill counter.
// Latency: match is combinational on the current s_in (same cycle as last sync bit).
// Backpressure: none; one bit is consumed every cycle while enabled.
module sync_matcher
  import serial_rx_pkg::*;
#(
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic s_in,
  output logic match
);

  localparam int FC_W = $clog2(SYNC_W + 1);

  logic [SYNC_W-1:0] sync_reg;
  logic [SYNC_W-1:0] sync_next;
  logic [FC_W-1:0]   fill_cnt;

  assign sync_next = {sync_reg[SYNC_W-2:0], s_in};

  // A match needs SYNC_W fresh bits since the last clear, so leftovers never fire.
  assign match = enable && (fill_cnt >= FC_W'(SYNC_W - 1)) && (sync_next == SYNC_PAT);

  // Shift in one bit per hunting cycle; fill count saturates at SYNC_W.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sync_reg <= '0;
      fill_cnt <= '0;
    end else if (enable) begin
      sync_reg <= sync_next;
      if (fill_cnt != FC_W'(SYNC_W)) begin
        fill_cnt <= fill_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: sync hunt, MSB-first payload deserialise, even-parity check.
// Latency: data_valid/parity_err high the cycle after the parity bit's sampling edge.
// Backpressure: none; the serial stream cannot be stalled, outputs are one-cycle pulses.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int                SYNC_W    = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = SYNC_PAT_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int BC_W = $clog2(DATA_W);

  rx_state_t         state;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] data_sr;
  logic              sync_match;

  // The matcher only looks at the line while hunting and is wiped as a frame ends.
  sync_matcher #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_sync_matcher (
    .clk    (clk),
    .reset  (reset),
    .enable (state == HUNT),
    .clear  (state == PARITY),
    .s_in   (s_in),
    .match  (sync_match)
  );

  // Frame FSM with registered pulses, lock flag and saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      bit_cnt    <= '0;
      data_sr    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      locked     <= 1'b0;
      err_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        HUNT: begin
          if (sync_match) begin
            state   <= DATA;
            bit_cnt <= '0;
            locked  <= 1'b1;
          end
        end
        DATA: begin
          // Payload bits are taken blindly; sync look-alikes here are just data.
          data_sr <= {data_sr[DATA_W-2:0], s_in};
          if (bit_cnt == BC_W'(DATA_W - 1)) begin
            state <= PARITY;
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        PARITY: begin
          if ((^data_sr ^ s_in) == 1'b0) begin
            data_out   <= data_sr;
            data_valid <= 1'b1;
          end else begin
            parity_err <= 1'b1;
            if (err_count != '1) begin
              err_count <= err_count + ERR_CNT_W'(1);
            end
          end
          state  <= HUNT;
          locked <= 1'b0;
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  localparam int         SW = 4;
  localparam logic [3:0] SP = 4'b1011;
  localparam int         DW = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_in;
  logic [7:0] data_out;
  logic       data_valid, parity_err, locked;
  logic [7:0] err_count;
  logic [7:0] data_out2;
  logic       data_valid2, parity_err2, locked2;
  logic [1:0] err_count2;

  always #5 clk = ~clk;

  serial_frame_rx #(.SYNC_W(SW), .SYNC_PAT(SP), .DATA_W(DW), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .s_in(s_in), .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .locked(locked), .err_count(err_count)
  );

  serial_frame_rx #(.SYNC_W(SW), .SYNC_PAT(SP), .DATA_W(DW), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .s_in(s_in), .data_out(data_out2), .data_valid(data_valid2),
    .parity_err(parity_err2), .locked(locked2), .err_count(err_count2)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int vtimes[$];

  // Reference model: a frame is "SYNC_W most recent bits equal the pattern"
  // followed by DATA_W+1 bits whose total count of ones must be even.
  bit         hunting = 1'b1;
  bit         hist[$];
  bit         pay[$];
  logic [7:0] exp_data = '0;
  bit         exp_valid = 1'b0;
  bit         exp_perr = 1'b0;
  int         exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model(input bit b, input bit r);
    logic [SW-1:0] w;
    int ones;
    if (r) begin
      hunting = 1'b1; hist = {}; pay = {};
      exp_data = '0; exp_valid = 1'b0; exp_perr = 1'b0; exp_err = 0;
      return;
    end
    exp_valid = 1'b0;
    exp_perr  = 1'b0;
    if (hunting) begin
      hist.push_back(b);
      if (hist.size() > SW) void'(hist.pop_front());
      if (hist.size() == SW) begin
        w = '0;
        foreach (hist[i]) w = {w[SW-2:0], hist[i]};
        if (w == SP) begin
          hunting = 1'b0;
          pay = {};
        end
      end
    end else begin
      pay.push_back(b);
      if (pay.size() == DW + 1) begin
        ones = 0;
        foreach (pay[i]) ones += int'(pay[i]);
        if (ones % 2 == 0) begin
          for (int i = 0; i < DW; i++) exp_data[DW-1-i] = pay[i];
          exp_valid = 1'b1;
        end else begin
          exp_perr = 1'b1;
          exp_err++;
        end
        hunting = 1'b1;
        hist = {};
      end
    end
  endtask

  task automatic check_all();
    chk("locked", 32'(locked), 32'(!hunting));
    chk("data_valid", 32'(data_valid), 32'(exp_valid));
    chk("parity_err", 32'(parity_err), 32'(exp_perr));
    chk("data_out", 32'(data_out), 32'(exp_data));
    chk("err_count", 32'(err_count), 32'((exp_err > 255) ? 255 : exp_err));
    chk("err_count_w2", 32'(err_count2), 32'((exp_err > 3) ? 3 : exp_err));
    if (data_valid === 1'b1) vtimes.push_back(cyc);
  endtask

  task automatic step(input logic b, input logic r);
    s_in  = b;
    reset = r;
    @(posedge clk);
    cyc++;
    model(b, r);
    #1;
    check_all();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad);
    send_bits(32'(SP), SW);
    send_bits(32'(d), DW);
    step(^d ^ bad, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    int gap;
    s_in  = 1'b0;
    reset = 1'b1;

    // Reset state, then idle zeros never lock.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    // Good frame 0xA5, then the same frame with bad parity.
    send_frame(8'hA5, 1'b0);
    step(1'b0, 1'b0);
    send_frame(8'hA5, 1'b1);
    step(1'b0, 1'b0);
    chk("data_out_held", 32'(data_out), 32'h000000A5);

    // Back-to-back frames: two valid pulses exactly one frame period apart.
    vtimes = {};
    send_frame(8'h3C, 1'b0);
    send_frame(8'hFF, 1'b0);
    step(1'b0, 1'b0);
    chk("b2b_count", 32'(vtimes.size()), 32'd2);
    if (vtimes.size() >= 2) chk("b2b_gap", 32'(vtimes[1] - vtimes[0]), 32'(SW + DW + 1));

    // Reset mid-frame abandons it; a following frame still decodes.
    send_bits(32'(SP), SW);
    send_bits(32'hA, 4);
    step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    send_frame(8'h5A, 1'b0);
    step(1'b0, 1'b0);

    // Five bad frames whose payload contains the sync pattern; narrow counter saturates.
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_frame(8'h2D, 1'b1);
    step(1'b0, 1'b0);
    chk("err_sat_w2", 32'(err_count2), 32'd3);
    chk("err_w8", 32'(err_count), 32'd5);

    // Randomized frames with random gap noise and occasional resets.
    for (int n = 0; n < 250; n++) begin
      gap = $urandom_range(0, 6);
      for (int i = 0; i < gap; i++) step(1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 24) == 0) step(1'($urandom_range(0, 1)), 1'b1);
      d = 8'($urandom);
      send_frame(d, ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
